// File: rtl/mag_cmp_arbiter.sv
// Round-robin arbiter that feeds a one-deep registered magnitude comparator.
// Optional macro MAG_CMP_ARB_SIGNED_EN selects two's-complement comparison.
module mag_cmp_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic                  eq,
  output logic                  gt,
  output logic                  lt,
  input  logic                  res_ready
);

  typedef enum logic {IDLE, RESULT} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;

  logic             w_canAccept;
  logic             w_found;
  logic             w_grant;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_ptrNext;
  logic [IDW:0]     w_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;

  // rst_n gates acceptance so req_ready stays low throughout reset.
  assign w_canAccept = rst_n && ((r_state == IDLE) || res_ready);

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[IDW-1:0];
      end
    end
  end

  assign w_grant   = w_canAccept && w_found;
  assign w_ptrNext = (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  assign w_a = req_a[int'(w_winner)*WIDTH +: WIDTH];
  assign w_b = req_b[int'(w_winner)*WIDTH +: WIDTH];

  assign w_eq = (w_a == w_b);
`ifdef MAG_CMP_ARB_SIGNED_EN
  assign w_gt = ($signed(w_a) > $signed(w_b));
  assign w_lt = ($signed(w_a) < $signed(w_b));
`else
  assign w_gt = (w_a > w_b);
  assign w_lt = (w_a < w_b);
`endif

  // A grant always (re)loads the result; RESULT falls back to IDLE only when consumed with no new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
    end else if (w_grant) begin
      r_state   <= RESULT;
      r_ptr     <= w_ptrNext;
      res_valid <= 1'b1;
      res_id    <= w_winner;
      eq        <= w_eq;
      gt        <= w_gt;
      lt        <= w_lt;
    end else if ((r_state == RESULT) && res_ready) begin
      r_state   <= IDLE;
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mag_cmp_arbiter.sv
// Scoreboard bench for mag_cmp_arbiter: driver pushes expected results on each grant,
// a negedge monitor pops them when the consumer takes a result.
`timescale 1ns/1ps

`ifdef MAG_CMP_ARB_SIGNED_EN
`define TB_EXP(u, s) (s)
`else
`define TB_EXP(u, s) (u)
`endif

module tb_mag_cmp_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic                  clock;
  logic                  rstN;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*WIDTH-1:0] reqA;
  logic [NREQ*WIDTH-1:0] reqB;
  logic [NREQ-1:0]       reqReady;
  logic                  resValid;
  logic [1:0]            resId;
  logic                  eqOut;
  logic                  gtOut;
  logic                  ltOut;
  logic                  resReady;

  int checks = 0;
  int errors = 0;
  logic [4:0] sbQueue[$];

  mag_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clock),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_ready (reqReady),
    .res_valid (resValid),
    .res_id    (resId),
    .eq        (eqOut),
    .gt        (gtOut),
    .lt        (ltOut),
    .res_ready (resReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clock) begin
    if (rstN && resValid && resReady) begin
      checks++;
      if (sbQueue.size() == 0) begin
        errors++;
        $display("[TB] FAIL result: got id=%0d flags=%b, expected none", resId, {eqOut, gtOut, ltOut});
      end else begin
        logic [4:0] exp;
        exp = sbQueue.pop_front();
        if ({resId, eqOut, gtOut, ltOut} !== exp) begin
          errors++;
          $display("[TB] FAIL result: got id=%0d flags=%b, expected id=%0d flags=%b",
                   resId, {eqOut, gtOut, ltOut}, exp[4:3], exp[2:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, check the grant before the edge, record the expected result.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [15:0] a,
                               input logic [15:0] b, input logic rr, input int expId,
                               input logic [2:0] expFlags, input string name);
    logic [NREQ-1:0] expReady;
    reqValid = valid;
    reqA     = a;
    reqB     = b;
    resReady = rr;
    @(negedge clock);
    expReady = (expId < 0) ? '0 : (NREQ'(1) << expId);
    checks++;
    if (reqReady !== expReady) begin
      errors++;
      $display("[TB] FAIL %s grant: req_ready=%b expected %b", name, reqReady, expReady);
    end
    if (expId >= 0) sbQueue.push_back({2'(expId), expFlags});
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input logic expValid, input int expId,
                             input logic [2:0] expFlags, input string name);
    checks++;
    if ({resValid, resId, eqOut, gtOut, ltOut} !== {expValid, 2'(expId), expFlags}) begin
      errors++;
      $display("[TB] FAIL %s: valid=%b id=%0d flags=%b expected valid=%b id=%0d flags=%b",
               name, resValid, resId, {eqOut, gtOut, ltOut}, expValid, expId, expFlags);
    end
  endtask

  task automatic checkReady(input logic [NREQ-1:0] expReady, input string name);
    checks++;
    if (reqReady !== expReady) begin
      errors++;
      $display("[TB] FAIL %s: req_ready=%b expected %b", name, reqReady, expReady);
    end
  endtask

  initial begin
    rstN     = 1'b0;
    reqValid = 4'b1111;
    reqA     = 16'h1234;
    reqB     = 16'h4321;
    resReady = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput(1'b0, 0, 3'b000, "reset_outputs");
    checkReady(4'b0000, "reset_ready");
    reqValid = 4'b0000;
    rstN     = 1'b1;
    @(posedge clock);
    #1;

    // Single requester 0, equal operands; non-granted slices carry junk.
    applyStimulus(4'b0001, 16'h9A35, 16'h6B25, 1'b1, 0, EQ, "eq_5_5");
    checkOutput(1'b1, 0, EQ, "eq_5_5_result");
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, -1, 3'b000, "idle_0");
    checkOutput(1'b0, 0, EQ, "idle_0_result");

    // Single requester 3 (ptr=1 wraps to 3).
    applyStimulus(4'b1000, 16'hC5A1, 16'h7E2B, 1'b1, 3, `TB_EXP(GT, LT), "c_vs_7");
    applyStimulus(4'b1000, 16'h3F00, 16'h9111, 1'b1, 3, `TB_EXP(LT, GT), "3_vs_9");
    applyStimulus(4'b1000, 16'h0ABC, 16'hF000, 1'b1, 3, `TB_EXP(LT, GT), "0_vs_f");
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, -1, 3'b000, "idle_1");

    // All requesting, back-to-back: r0 5/2, r1 8/8, r2 3/9, r3 F/0.
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 0, GT, "rr_0");
    checkOutput(1'b1, 0, GT, "rr_0_result");
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 1, EQ, "rr_1");
    checkOutput(1'b1, 1, EQ, "rr_1_result");
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 2, `TB_EXP(LT, GT), "rr_2");
    checkOutput(1'b1, 2, `TB_EXP(LT, GT), "rr_2_result");
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 3, `TB_EXP(GT, LT), "rr_3");
    checkOutput(1'b1, 3, `TB_EXP(GT, LT), "rr_3_result");
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 0, GT, "rr_0_again");
    checkOutput(1'b1, 0, GT, "rr_0_again_result");
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, -1, 3'b000, "idle_2");

    // Backpressure: result F/0 from requester 1 held while everyone requests.
    applyStimulus(4'b0010, 16'h3AF7, 16'h5C0E, 1'b1, 1, `TB_EXP(GT, LT), "f_vs_0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 16'h1357 + 16'(i), 16'hECA8, 1'b0, -1, 3'b000, "hold");
      checkOutput(1'b1, 1, `TB_EXP(GT, LT), "hold_result");
    end
    applyStimulus(4'b0010, 16'h2A7C, 16'h3E9D, 1'b1, 1, `TB_EXP(LT, GT), "release");
    checkOutput(1'b1, 1, `TB_EXP(LT, GT), "release_result");

    // Reset with a held result and ptr=2: outputs clear at once, ptr restarts at 0.
    resReady = 1'b0;
    reqValid = 4'b0000;
    rstN     = 1'b0;
    #1;
    checkOutput(1'b0, 0, 3'b000, "midrun_reset");
    checkReady(4'b0000, "midrun_reset_ready");
    sbQueue.delete();
    @(negedge clock);
    rstN = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 0, GT, "post_reset_0");
    applyStimulus(4'b1111, 16'hF385, 16'h0982, 1'b1, 1, EQ, "post_reset_1");
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, -1, 3'b000, "idle_3");
    applyStimulus(4'b0000, 16'h0000, 16'h0000, 1'b1, -1, 3'b000, "idle_4");

    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sbQueue.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
